compare_window_tally: RTL and testbench

- Downstream consumer of the 4-bit magnitude comparator stage.
- Accepts one operand pair (a, b) per handshake, together with the comparator's equal/agreater/bgreater flags for that pair.
- Over a fixed window of WINDOW well-formed pairs it tallies A wins, B wins and ties, and tracks the largest winning value.
- It then presents one report word on a valid/ready output handshake and re-arms for the next window.

---
 rtl/compare_window_tally.sv | 98 +++++++++
 tb/tb_compare_window_tally.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_window_tally.sv
// Tallies comparator outcomes over a window of well-formed operand pairs
// and hands one report word downstream per window on a valid/ready handshake.
//
// state  | meaning
// ACCUM  | accepting pairs, running totals visible, in_ready=1
// REPORT | window complete, totals held, out_valid=1 until out_ready
module compare_window_tally #(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             equal,
    input  logic             agreater,
    input  logic             bgreater,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] a_wins,
    output logic [CNT_W-1:0] b_wins,
    output logic [CNT_W-1:0] ties,
    output logic [3:0]       max_val,
    output logic             flag_err
);

    localparam logic [0:0]       ACCUM    = 1'b0;
    localparam logic [0:0]       REPORT   = 1'b1;
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW);

    logic [0:0]       state;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             well_formed;
    logic             last_pair;
    logic [3:0]       winner;

    always_comb begin
        well_formed = 1'b0;
        case ({equal, agreater, bgreater})
            3'b100,
            3'b010,
            3'b001:  well_formed = 1'b1;
            default: well_formed = 1'b0;
        endcase
    end

    // Ties credit a as the winner; its value equals b anyway.
    assign winner    = bgreater ? b : a;
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == REPORT);
    assign accept    = in_valid && in_ready;
    assign last_pair = (remaining == CNT_W'(1));

    // remaining counts down from WINDOW; the terminal count marks the last pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            remaining <= WIN_LOAD;
            a_wins    <= '0;
            b_wins    <= '0;
            ties      <= '0;
            max_val   <= '0;
            flag_err  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (well_formed) begin
                            if (agreater) a_wins <= a_wins + CNT_W'(1);
                            if (bgreater) b_wins <= b_wins + CNT_W'(1);
                            if (equal)    ties   <= ties + CNT_W'(1);
                            if (winner > max_val) max_val <= winner;
                            remaining <= remaining - CNT_W'(1);
                            if (last_pair) state <= REPORT;
                        end else begin
                            flag_err <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        remaining <= WIN_LOAD;
                        a_wins    <= '0;
                        b_wins    <= '0;
                        ties      <= '0;
                        max_val   <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_window_tally.sv
// Randomized and directed bench for compare_window_tally against a window-level
// reference model; a second instance runs with a one-pair window.
module tb_compare_window_tally;

    localparam int W  = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, equal, agreater, bgreater, out_ready;
    logic [3:0]    a, b;
    logic          in_ready, out_valid, flag_err;
    logic [CW-1:0] a_wins, b_wins, ties;
    logic [3:0]    max_val;

    logic          in_valid1, equal1, agreater1, bgreater1, out_ready1;
    logic [3:0]    a1, b1;
    logic          in_ready1, out_valid1, flag_err1;
    logic [CW-1:0] a_wins1, b_wins1, ties1;
    logic [3:0]    max_val1;

    compare_window_tally #(.WINDOW(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .equal(equal), .agreater(agreater), .bgreater(bgreater),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_wins(a_wins), .b_wins(b_wins), .ties(ties),
        .max_val(max_val), .flag_err(flag_err)
    );

    compare_window_tally #(.WINDOW(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .equal(equal1), .agreater(agreater1), .bgreater(bgreater1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .a_wins(a_wins1), .b_wins(b_wins1), .ties(ties1),
        .max_val(max_val1), .flag_err(flag_err1)
    );

    int checks = 0;
    int errors = 0;

    // reference model: what a window has collected so far
    int         m_a, m_b, m_t, m_n;
    int         m_max;
    bit         m_err, m_rep;

    logic [30:0] dut_vec;
    assign dut_vec = {in_ready, out_valid, a_wins, b_wins, ties, max_val, flag_err};

    function automatic logic [30:0] exp_vec();
        return {!m_rep, m_rep, 8'(m_a), 8'(m_b), 8'(m_t), 4'(m_max), m_err};
    endfunction

    function automatic int nflags();
        return int'(equal) + int'(agreater) + int'(bgreater);
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_t = 0; m_n = 0; m_max = 0;
    endtask

    // advance the model by one edge using the currently driven inputs, then clock
    task automatic tick();
        if (rst) begin
            model_clear();
            m_err = 0;
            m_rep = 0;
        end else if (m_rep) begin
            if (out_ready) begin
                model_clear();
                m_rep = 0;
            end
        end else if (in_valid) begin
            if (nflags() == 1) begin
                int win;
                win = bgreater ? int'(b) : int'(a);
                m_a += int'(agreater);
                m_b += int'(bgreater);
                m_t += int'(equal);
                if (win > m_max) m_max = win;
                m_n++;
                if (m_n == W) m_rep = 1;
            end else begin
                m_err = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [3:0] pa, input logic [3:0] pb, input logic [2:0] f);
        a = pa; b = pb;
        {equal, agreater, bgreater} = f;
    endtask

    function automatic logic [2:0] rand_good();
        logic [2:0] one;
        one = 3'b001;
        return one << $urandom_range(0, 2);
    endfunction

    task automatic test_reset();
        rst = 1; in_valid = 1; out_ready = 0;
        drive_pair(4'd9, 4'd3, 3'b010);
        in_valid1 = 1; out_ready1 = 0; a1 = 0; b1 = 0;
        {equal1, agreater1, bgreater1} = 3'b100;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dut_vec !== {1'b1, 1'b0, 29'd0}) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %h want %h", i, dut_vec, {1'b1, 1'b0, 29'd0});
            end
        end
        rst = 0; in_valid = 0; in_valid1 = 0;
        checks++;
        if (in_ready !== 1'b1 || a_wins !== 0 || b_wins !== 0 || ties !== 0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got rdy=%b aw=%0d bw=%0d t=%0d rdy1=%b want rdy=1 counts 0",
                     in_ready, a_wins, b_wins, ties, in_ready1);
        end
    endtask

    task automatic test_mixed_window();
        logic [2:0]  fl [8];
        logic [3:0]  pa [8];
        logic [3:0]  pb [8];
        pa = '{4'b1001, 4'b1001, 4'b1101, 4'b1011, 4'b1101, 4'b1111, 4'b1101, 4'b0110};
        pb = '{4'b1000, 4'b1010, 4'b1100, 4'b1100, 4'b1100, 4'b1101, 4'b1110, 4'b0110};
        fl = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001, 3'b100};
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            drive_pair(pa[i], pb[i], fl[i]);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL mixed_pair%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || a_wins !== 8'd4 || b_wins !== 8'd3 || ties !== 8'd1 || max_val !== 4'b1111) begin
            errors++;
            $display("FAIL mixed_report got v=%b aw=%0d bw=%0d t=%0d max=%b want v=1 4 3 1 1111",
                     out_valid, a_wins, b_wins, ties, max_val);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || a_wins !== 0 || b_wins !== 0 || ties !== 0 || max_val !== 0) begin
            errors++;
            $display("FAIL mixed_after_hs got rdy=%b v=%b aw=%0d bw=%0d t=%0d max=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, a_wins, b_wins, ties, max_val);
        end
    endtask

    task automatic fill_window(input bit hold_report);
        out_ready = hold_report ? 1'b0 : 1'b1;
        in_valid = 1;
        while (!m_rep) begin
            drive_pair(4'($urandom), 4'($urandom), rand_good());
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL fill n=%0d got %h want %h", m_n, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [30:0] snap;
        fill_window(1);
        snap = dut_vec;
        checks++;
        if (out_valid !== 1'b1 || int'(a_wins) + int'(b_wins) + int'(ties) != W) begin
            errors++;
            $display("FAIL bp_report got v=%b sum=%0d want v=1 sum=%0d",
                     out_valid, int'(a_wins) + int'(b_wins) + int'(ties), W);
        end
        for (int i = 0; i < 5; i++) begin
            drive_pair(4'hF, 4'h0, 3'b010);
            tick();
            checks++;
            if (dut_vec !== snap || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got %h want %h", i, dut_vec, snap);
            end
        end
        in_valid = 0; out_ready = 1;
        tick();
        checks++;
        if (dut_vec !== exp_vec() || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_malformed();
        logic [2:0] bad [2];
        bad = '{3'b011, 3'b000};
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 2; i++) begin
            drive_pair(4'd12, 4'd3, bad[i]);
            tick();
            checks++;
            if (flag_err !== 1'b1 || a_wins !== 0 || b_wins !== 0 || ties !== 0 || max_val !== 0) begin
                errors++;
                $display("FAIL malformed%0d got err=%b aw=%0d bw=%0d t=%0d max=%0d want err=1 counts 0",
                         i, flag_err, a_wins, b_wins, ties, max_val);
            end
        end
        fill_window(1);
        checks++;
        if (out_valid !== 1'b1 || flag_err !== 1'b1) begin
            errors++;
            $display("FAIL malformed_report got v=%b err=%b want 1 1", out_valid, flag_err);
        end
        out_ready = 1; in_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        fill_window(1);
        rst = 1; out_ready = 1; in_valid = 1;
        tick();
        rst = 0; in_valid = 0;
        checks++;
        if (dut_vec !== {1'b1, 1'b0, 29'd0}) begin
            errors++;
            $display("FAIL reset_mid got %h want %h", dut_vec, {1'b1, 1'b0, 29'd0});
        end
    endtask

    task automatic test_back_to_back();
        logic [30:0] got;
        logic [30:0] want [4];
        want[0] = {1'b0, 1'b1, 8'd0, 8'd1, 8'd0, 4'b0101, 1'b0};
        want[1] = {1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0};
        want[2] = {1'b0, 1'b1, 8'd0, 8'd0, 8'd1, 4'b0111, 1'b0};
        want[3] = {1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0};
        in_valid1 = 1; out_ready1 = 1;
        a1 = 4'b0011; b1 = 4'b0101; {equal1, agreater1, bgreater1} = 3'b001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                a1 = 4'b0111; b1 = 4'b0111; {equal1, agreater1, bgreater1} = 3'b100;
            end
            got = {in_ready1, out_valid1, a_wins1, b_wins1, ties1, max_val1, flag_err1};
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL b2b cyc%0d got %h want %h", i, got, want[i]);
            end
        end
        in_valid1 = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0)
                drive_pair(4'($urandom), 4'($urandom), 3'($urandom));
            else
                drive_pair(4'($urandom), 4'($urandom), rand_good());
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        rst = 0; in_valid = 0;
    endtask

    initial begin
        m_a = 0; m_b = 0; m_t = 0; m_n = 0; m_max = 0; m_err = 0; m_rep = 0;
        rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0;
        equal = 0; agreater = 0; bgreater = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0;
        equal1 = 0; agreater1 = 0; bgreater1 = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_mixed_window();
        test_backpressure();
        test_malformed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
